// File: rtl/adder_sum_accumulator.sv
// Streaming block-sum accumulator: adds COUNT adder sums, then holds the total for a downstream handshake.
// Build option: define ADDER_ACC_SATURATE_EN to clamp the total on overflow instead of wrapping.
module adder_sum_accumulator #(
   parameter int unsigned SUM_W = 10,
   parameter int unsigned ACC_W = 13,
   parameter int unsigned COUNT = 8,
   parameter int unsigned CNT_W = $clog2(COUNT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SUM_W-1:0] S,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic             clear,
   output logic [ACC_W-1:0] acc,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [CNT_W-1:0] acc_count,
   output logic             overflow
);

   typedef enum logic {StAccum, StHold} state_e;

   state_e           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;

   logic [ACC_W:0]   w_sum;
   logic [ACC_W-1:0] w_acc_next;
   logic             w_take;
   logic             w_last;

   // reset is included so the source sees no ready while the block is being reset
   assign s_ready = (r_state == StAccum) && !clear && !reset;
   assign w_take  = s_valid && s_ready;
   assign w_sum   = {1'b0, r_acc} + {{(ACC_W + 1 - SUM_W){1'b0}}, S};
   assign w_last  = (r_cnt == CNT_W'(COUNT - 1));

`ifdef ADDER_ACC_SATURATE_EN
   assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign w_acc_next = w_sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_state <= StAccum;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         unique case (r_state)
            StAccum: begin
               if (w_take) begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_sum[ACC_W]) r_ovf <= 1'b1;
                  if (w_last) r_state <= StHold;
               end
            end
            StHold: begin
               if (acc_ready) begin
                  r_state <= StAccum;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_ovf   <= 1'b0;
               end
            end
            default: r_state <= StAccum;
         endcase
      end
   end

   assign acc       = r_acc;
   assign acc_count = r_cnt;
   assign overflow  = r_ovf;
   assign acc_valid = (r_state == StHold);

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Bench for adder_sum_accumulator: a 13-bit and a 10-bit accumulator share one stimulus stream,
// checked against a block-sum reference model with a scoreboard of completed totals.
module tb_adder_sum_accumulator;
   localparam int unsigned SUM_W = 10;
   localparam int unsigned COUNT = 8;
   localparam int unsigned CNT_W = 4;
`ifdef ADDER_ACC_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             s_valid = 1'b0;
   logic             clear = 1'b0;
   logic             acc_ready = 1'b0;
   logic [SUM_W-1:0] S = '0;

   logic             s_ready13, acc_valid13, ovf13;
   logic             s_ready10, acc_valid10, ovf10;
   logic [12:0]      acc13;
   logic [9:0]       acc10;
   logic [CNT_W-1:0] cnt13, cnt10;

   int n_tests = 0;
   int n_fail = 0;
   bit rand_rdy = 1'b0;

   always #5 clk = ~clk;

   adder_sum_accumulator u13 (
      .clk(clk), .reset(reset), .S(S), .s_valid(s_valid), .s_ready(s_ready13), .clear(clear),
      .acc(acc13), .acc_valid(acc_valid13), .acc_ready(acc_ready), .acc_count(cnt13),
      .overflow(ovf13)
   );

   adder_sum_accumulator #(.ACC_W(10)) u10 (
      .clk(clk), .reset(reset), .S(S), .s_valid(s_valid), .s_ready(s_ready10), .clear(clear),
      .acc(acc10), .acc_valid(acc_valid10), .acc_ready(acc_ready), .acc_count(cnt10),
      .overflow(ovf10)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int unsigned a13;
      bit          o13;
      int unsigned a10;
      bit          o10;
   } exp_t;

   int unsigned m_samples[$];
   exp_t        exp_q[$];
   exp_t        m_e;
   bit          m_hold = 1'b0;
   bit          m_init = 1'b0;

   function automatic int unsigned total_of();
      int unsigned t = 0;
      foreach (m_samples[i]) t += m_samples[i];
      return t;
   endfunction

   // Block total as seen in a w-bit accumulator: true sum, wrapped or clamped.
   function automatic void fold(input int unsigned total, input int unsigned w,
                                output int unsigned a, output bit o);
      int unsigned mx = (32'd1 << w) - 1;
      o = (total > mx);
      if (!o) a = total;
      else if (SAT) a = mx;
      else a = total % (mx + 1);
   endfunction

   always @(posedge clk) begin
      if (reset || clear) begin
         if (reset) m_init = 1'b1;
         if (m_hold && exp_q.size() > 0) void'(exp_q.pop_back());
         m_samples.delete();
         m_hold = 1'b0;
      end else if (m_hold) begin
         if (acc_ready) begin
            m_hold = 1'b0;
            m_samples.delete();
         end
      end else if (s_valid) begin
         m_samples.push_back(int'(S));
         if (m_samples.size() == COUNT) begin
            fold(total_of(), 13, m_e.a13, m_e.o13);
            fold(total_of(), 10, m_e.a10, m_e.o10);
            exp_q.push_back(m_e);
            m_hold = 1'b1;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   int unsigned pa;
   bit          po;
   bit          exp_rdy;
   exp_t        got_e;

   always @(negedge clk) begin
      if (m_init) begin
         exp_rdy = !m_hold && !clear && !reset;
         chk("s_ready13", s_ready13, exp_rdy);
         chk("s_ready10", s_ready10, exp_rdy);
         chk("acc_valid13", acc_valid13, m_hold);
         chk("acc_valid10", acc_valid10, m_hold);
         chk("acc_count13", cnt13, m_samples.size());
         chk("acc_count10", cnt10, m_samples.size());
         fold(total_of(), 13, pa, po);
         chk("acc13", acc13, pa);
         chk("overflow13", ovf13, po);
         fold(total_of(), 10, pa, po);
         chk("acc10", acc10, pa);
         chk("overflow10", ovf10, po);
         if (acc_valid13 && acc_ready && !clear && !reset) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL sb_unexpected: got a total, expected none (t=%0t)", $time);
            end else begin
               got_e = exp_q.pop_front();
               chk("blk_acc13", acc13, got_e.a13);
               chk("blk_ovf13", ovf13, got_e.o13);
               chk("blk_acc10", acc10, got_e.a10);
               chk("blk_ovf10", ovf10, got_e.o10);
               chk("blk_count", cnt13, COUNT);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_rdy) acc_ready = ($urandom_range(0, 3) == 0);
   endtask

   // Called just after a rising edge; returns just after the edge that took the sample.
   task automatic send(input int unsigned v);
      bit ok;
      s_valid = 1'b1;
      S = SUM_W'(v);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         ok = s_ready13;
         tick();
         if (ok) return;
      end
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no handshake, expected one within 400 cycles");
   endtask

   task automatic dump();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_s_ready", s_ready13, 1);
      chk("post_reset_acc", acc13, 0);
      tick();

      // basic block
      for (int i = 0; i < 8; i++) send(1022);
      s_valid = 1'b0;
      @(negedge clk);
      chk("basic_valid", acc_valid13, 1);
      chk("basic_acc", acc13, 8176);
      chk("basic_count", cnt13, 8);
      chk("basic_ovf", ovf13, 0);
      chk("basic_s_ready", s_ready13, 0);

      // backpressure: offered samples must not be taken while holding
      s_valid = 1'b1;
      S = 10'd5;
      repeat (5) tick();
      @(negedge clk);
      chk("bp_acc_stable", acc13, 8176);
      chk("bp_count_stable", cnt13, 8);
      tick();
      acc_ready = 1'b1;
      tick();
      acc_ready = 1'b0;
      @(negedge clk);
      chk("bp_valid_fall", acc_valid13, 0);
      chk("bp_s_ready_rise", s_ready13, 1);
      tick();
      for (int i = 0; i < 7; i++) send(5);
      s_valid = 1'b0;
      @(negedge clk);
      chk("bp_acc40", acc13, 40);
      tick();
      dump();

      // gapped input
      for (int v = 1; v <= 8; v++) begin
         s_valid = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
         send(v);
      end
      s_valid = 1'b0;
      @(negedge clk);
      chk("gap_acc36", acc13, 36);
      chk("gap_count", cnt13, 8);
      tick();
      dump();

      // clear mid-block
      send(100);
      send(200);
      send(300);
      S = 10'd400;
      clear = 1'b1;
      @(negedge clk);
      chk("clr_s_ready", s_ready13, 0);
      tick();
      clear = 1'b0;
      s_valid = 1'b0;
      @(negedge clk);
      chk("clr_acc", acc13, 0);
      chk("clr_count", cnt13, 0);
      tick();
      for (int i = 0; i < 8; i++) send(1);
      s_valid = 1'b0;
      @(negedge clk);
      chk("clr_acc8", acc13, 8);
      tick();
      dump();

      // overflow on the 10-bit instance
      for (int i = 0; i < 8; i++) send(200);
      s_valid = 1'b0;
      @(negedge clk);
      chk("ovf_acc10", acc10, SAT ? 1023 : 576);
      chk("ovf_flag10", ovf10, 1);
      chk("ovf_acc13", acc13, 1600);
      chk("ovf_flag13", ovf13, 0);
      tick();
      dump();
      @(negedge clk);
      chk("ovf_cleared", ovf10, 0);
      tick();

      // reset while holding a total
      for (int i = 0; i < 8; i++) send($urandom_range(0, 1023));
      s_valid = 1'b0;
      @(negedge clk);
      chk("rst_hold_valid", acc_valid13, 1);
      tick();
      reset = 1'b1;
      tick();
      @(negedge clk);
      chk("rst_valid_drop", acc_valid13, 0);
      chk("rst_acc_zero", acc13, 0);
      chk("rst_s_ready_low", s_ready13, 0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_s_ready_high", s_ready13, 1);
      tick();

      // randomized traffic with random gaps, backpressure and clears
      rand_rdy = 1'b1;
      for (int n = 0; n < 300; n++) begin
         s_valid = 1'b0;
         if ($urandom_range(0, 30) == 0) begin
            clear = 1'b1;
            tick();
            clear = 1'b0;
         end
         repeat ($urandom_range(0, 2)) tick();
         send($urandom_range(0, 1023));
      end
      s_valid = 1'b0;
      rand_rdy = 1'b0;
      acc_ready = 1'b1;
      repeat (3) tick();
      acc_ready = 1'b0;
      @(negedge clk);
      chk("sb_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
